// File: rtl/uart_cmd_decoder_pkg.sv
// Shared command codes, control-byte layout and decoder state encoding.
package uart_cmd_decoder_pkg;

   localparam logic [7:0] CMD_DATA   = 8'h01;
   localparam logic [7:0] CMD_FREQ   = 8'h02;
   localparam logic [7:0] CMD_PERIOD = 8'h03;

   localparam logic [1:0] CTRL_TAG   = 2'b01;

   // Control byte layout, MSB first: {channel[7:4], rsvd[3], mode[2], tag[1:0]}
   typedef struct packed {
      logic [3:0] channel;
      logic       rsvd;
      logic       mode;
      logic [1:0] tag;
   } ctrl_byte_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FREQ,
      ST_PERIOD,
      ST_DATA,
      ST_CTRL
   } state_e;

endpackage

// File: rtl/uart_cmd_decoder_collector.sv
// Shifts bytes LSB-first into a DATA_BIT shadow word; flags the final byte of a word.
module uart_cmd_decoder_collector #(
   parameter int unsigned DATA_BIT = 32
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clear,
   input  logic                i_shift,
   input  logic [7:0]          i_byte,
   output logic [DATA_BIT-1:0] o_shadow,
   output logic [DATA_BIT-1:0] o_word_c,
   output logic                o_done_c
);

   localparam int unsigned NBYTES = DATA_BIT / 8;
   localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [CNT_W-1:0] r_cnt;

   // Word as it will look once the current byte is shifted in
   assign o_word_c = DATA_BIT'({i_byte, o_shadow} >> 8);
   assign o_done_c = i_shift && (r_cnt == CNT_W'(NBYTES - 1));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         o_shadow <= '0;
         r_cnt    <= '0;
      end else if (i_shift) begin
         o_shadow <= o_word_c;
         r_cnt    <= o_done_c ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Frames FREQ / PERIOD / DATA packets from the UART byte stream into
// configuration registers and per-channel load strobes.
module uart_cmd_decoder
   import uart_cmd_decoder_pkg::*;
#(
   parameter int unsigned DATA_BIT       = 32,
   parameter int unsigned OUTPUT_NUM     = 16,
   parameter logic [7:0]  SLOW_PERIOD    = 8'h14,
   parameter logic [7:0]  FAST_PERIOD    = 8'h05,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [7:0]          rx_data_i,
   input  logic                rx_done_tick_i,
   output logic [DATA_BIT-1:0] freq_pattern_o,
   output logic [7:0]          slow_period_o,
   output logic [7:0]          fast_period_o,
   output logic                cfg_update_tick_o,
   output logic [DATA_BIT-1:0] ch_data_o,
   output logic [3:0]          ch_sel_o,
   output logic                ch_mode_o,
   output logic                ch_load_tick_o,
   output logic                err_tick_o
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

   state_e              r_state, w_state_nxt;
   logic [TO_W-1:0]     r_to_cnt;
   logic [7:0]          r_slow_shd, w_slow_shd_nxt;
   logic                r_per_idx, w_per_idx_nxt;

   logic [DATA_BIT-1:0] w_freq_nxt, w_ch_data_nxt;
   logic [7:0]          w_slow_nxt, w_fast_nxt;
   logic [3:0]          w_ch_sel_nxt;
   logic                w_ch_mode_nxt;
   logic                w_cfg_tick_nxt, w_load_tick_nxt, w_err_tick_nxt;

   logic [DATA_BIT-1:0] w_shadow, w_word;
   logic                w_done, w_timeout, w_shift, w_clear, w_ctrl_ok;
   ctrl_byte_t          w_ctrl;

   assign w_ctrl    = ctrl_byte_t'(rx_data_i);
   assign w_ctrl_ok = (w_ctrl.tag == CTRL_TAG) && !w_ctrl.rsvd
                      && (32'(w_ctrl.channel) < OUTPUT_NUM);

   // A byte landing on the expiry cycle wins over the timeout
   assign w_timeout = (r_state != ST_IDLE) && !rx_done_tick_i
                      && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   assign w_shift = rx_done_tick_i && ((r_state == ST_FREQ) || (r_state == ST_DATA));
   assign w_clear = (r_state == ST_IDLE) || w_timeout;

   uart_cmd_decoder_collector #(
      .DATA_BIT (DATA_BIT)
   ) u_collector (
      .i_clk    (clk_i),
      .i_rst_n  (rst_ni),
      .i_clear  (w_clear),
      .i_shift  (w_shift),
      .i_byte   (rx_data_i),
      .o_shadow (w_shadow),
      .o_word_c (w_word),
      .o_done_c (w_done)
   );

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt     = r_state;
      w_slow_shd_nxt  = r_slow_shd;
      w_per_idx_nxt   = r_per_idx;
      w_freq_nxt      = freq_pattern_o;
      w_slow_nxt      = slow_period_o;
      w_fast_nxt      = fast_period_o;
      w_ch_data_nxt   = ch_data_o;
      w_ch_sel_nxt    = ch_sel_o;
      w_ch_mode_nxt   = ch_mode_o;
      w_cfg_tick_nxt  = 1'b0;
      w_load_tick_nxt = 1'b0;
      w_err_tick_nxt  = 1'b0;

      if (w_timeout) begin
         w_err_tick_nxt = 1'b1;
         w_state_nxt    = ST_IDLE;
      end else if (rx_done_tick_i) begin
         unique case (r_state)
            ST_IDLE: begin
               w_per_idx_nxt = 1'b0;
               case (rx_data_i)
                  CMD_FREQ:   w_state_nxt = ST_FREQ;
                  CMD_PERIOD: w_state_nxt = ST_PERIOD;
                  CMD_DATA:   w_state_nxt = ST_DATA;
                  default:    w_err_tick_nxt = 1'b1;
               endcase
            end
            ST_FREQ: begin
               if (w_done) begin
                  w_freq_nxt     = w_word;
                  w_cfg_tick_nxt = 1'b1;
                  w_state_nxt    = ST_IDLE;
               end
            end
            ST_PERIOD: begin
               if (!r_per_idx) begin
                  w_slow_shd_nxt = rx_data_i;
                  w_per_idx_nxt  = 1'b1;
               end else begin
                  if ((r_slow_shd != 8'h00) && (rx_data_i != 8'h00)) begin
                     w_slow_nxt     = r_slow_shd;
                     w_fast_nxt     = rx_data_i;
                     w_cfg_tick_nxt = 1'b1;
                  end else begin
                     w_err_tick_nxt = 1'b1;
                  end
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_DATA: begin
               if (w_done) begin
                  w_state_nxt = ST_CTRL;
               end
            end
            ST_CTRL: begin
               if (w_ctrl_ok) begin
                  w_ch_data_nxt   = w_shadow;
                  w_ch_sel_nxt    = w_ctrl.channel;
                  w_ch_mode_nxt   = w_ctrl.mode;
                  w_load_tick_nxt = 1'b1;
               end else begin
                  w_err_tick_nxt = 1'b1;
               end
               w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State, timeout counter and registered outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state           <= ST_IDLE;
         r_to_cnt          <= '0;
         r_slow_shd        <= '0;
         r_per_idx         <= 1'b0;
         freq_pattern_o    <= '0;
         slow_period_o     <= SLOW_PERIOD;
         fast_period_o     <= FAST_PERIOD;
         ch_data_o         <= '0;
         ch_sel_o          <= '0;
         ch_mode_o         <= 1'b0;
         cfg_update_tick_o <= 1'b0;
         ch_load_tick_o    <= 1'b0;
         err_tick_o        <= 1'b0;
      end else begin
         r_state           <= w_state_nxt;
         r_to_cnt          <= ((r_state == ST_IDLE) || rx_done_tick_i) ? '0 : r_to_cnt + TO_W'(1);
         r_slow_shd        <= w_slow_shd_nxt;
         r_per_idx         <= w_per_idx_nxt;
         freq_pattern_o    <= w_freq_nxt;
         slow_period_o     <= w_slow_nxt;
         fast_period_o     <= w_fast_nxt;
         ch_data_o         <= w_ch_data_nxt;
         ch_sel_o          <= w_ch_sel_nxt;
         ch_mode_o         <= w_ch_mode_nxt;
         cfg_update_tick_o <= w_cfg_tick_nxt;
         ch_load_tick_o    <= w_load_tick_nxt;
         err_tick_o        <= w_err_tick_nxt;
      end
   end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Parses the UART RX byte stream into register updates for the multi-channel serial output stage.
- Sits between the UART receiver (rx_done_tick / rx_data) and diff_freq_serial_out.
- Frames three command packets: FREQ, PERIOD and DATA.
- Holds the frequency pattern and slow/fast periods, and emits one-cycle load strobes for per-channel data.

Parameters:
- DATA_BIT, 32, width of data and frequency patterns; must be a multiple of 8.
- OUTPUT_NUM, 16, number of output channels; channel index width is 4.
- SLOW_PERIOD, 8'h14, reset value of slow_period_o.
- FAST_PERIOD, 8'h05, reset value of fast_period_o.
- TIMEOUT_CYCLES, 100000, inter-byte timeout in clk_i cycles.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, synchronous, active-low
- rx_data_i  in  8  received UART byte; valid only when rx_done_tick_i=1
- rx_done_tick_i  in  1  one-cycle byte strobe from the UART
- freq_pattern_o  out  DATA_BIT  per-bit slow(0)/fast(1) select pattern
- slow_period_o  out  8  slow bit period
- fast_period_o  out  8  fast bit period
- cfg_update_tick_o  out  1  pulse when freq or period registers change
- ch_data_o  out  DATA_BIT  data pattern for a channel load
- ch_sel_o  out  4  target channel
- ch_mode_o  out  1  0 = one-shot, 1 = repeat
- ch_load_tick_o  out  1  pulse; ch_data_o/ch_sel_o/ch_mode_o are valid this cycle
- err_tick_o  out  1  pulse on any protocol error

Behaviour:
- One clock, clk_i. Reset is synchronous, active-low, on rst_ni.
- Reset values:
  - freq_pattern_o=0, slow_period_o=SLOW_PERIOD, fast_period_o=FAST_PERIOD.
  - ch_data_o=0, ch_sel_o=0, ch_mode_o=0.
  - All ticks 0; state IDLE; byte counter 0; timeout counter 0.
- Command codes: CMD_DATA=8'h01, CMD_FREQ=8'h02, CMD_PERIOD=8'h03.
- Multi-byte fields are sent LSB byte first and assembled into a shadow register. Outputs are never partially updated.
- States:
  - IDLE:
    - CMD_FREQ -> FREQ; CMD_PERIOD -> PERIOD; CMD_DATA -> DATA. Each clears the byte counter.
    - Any other byte -> err_tick_o, stay IDLE.
  - FREQ: collect DATA_BIT/8 bytes. On the last byte, copy shadow to freq_pattern_o, pulse cfg_update_tick_o, go IDLE.
  - PERIOD: byte 0 = slow, byte 1 = fast.
    - On byte 1, if both are nonzero: update both outputs together and pulse cfg_update_tick_o.
    - Otherwise pulse err_tick_o and leave both outputs unchanged.
    - Go IDLE either way.
  - DATA: collect DATA_BIT/8 bytes into the shadow, then -> CTRL.
  - CTRL: control byte = {channel[7:4], rsvd[3], mode[2], tag[1:0]}.
    - Valid when tag=2'b01, rsvd=0 and channel<OUTPUT_NUM. Then drive ch_data_o, ch_sel_o and ch_mode_o, and pulse ch_load_tick_o.
    - Otherwise pulse err_tick_o and do not pulse ch_load_tick_o.
    - Go IDLE either way.
- Latency: outputs and tick are registered; they appear in the cycle after the final byte's rx_done_tick_i. ch_* values hold until the next load.
- Ticks last exactly one cycle. err_tick_o and a load/update tick are never asserted together.
- Timeout:
  - Counter clears on every rx_done_tick_i and while in IDLE.
  - In any other state, reaching TIMEOUT_CYCLES-1 pulses err_tick_o, returns to IDLE and discards the partial packet.
  - If rx_done_tick_i coincides with timeout expiry, the byte is accepted and the timeout is suppressed.
- Back-to-back packets: a command byte arriving on the cycle after packet completion is accepted normally.
- Reset mid-packet: the partial packet is discarded and no tick is issued.
- rx_data_i is ignored when rx_done_tick_i=0.

Decomposition:
- Shared header/package holds:
  - CMD_DATA, CMD_FREQ, CMD_PERIOD.
  - Control-byte field positions and CTRL_TAG=2'b01.
  - State encoding (IDLE, FREQ, PERIOD, DATA, CTRL).
- Optional sub-module: byte_shift_collector. It shifts bytes into a DATA_BIT shadow register, LSB first, and has a byte counter and a done flag. It is reused by FREQ and DATA.
- Timeout counter stays inline.

Test Plan:
- FREQ 8'h02, 55,55,55,55 -> freq_pattern_o=32'h5555_5555 one cycle after last byte; cfg_update_tick_o one pulse; no err.
- PERIOD 8'h03, 14, 05 -> slow_period_o=8'h14, fast_period_o=8'h05, cfg_update_tick_o pulse.
- PERIOD 8'h03, 00, 05 -> err_tick_o pulse; periods unchanged.
- DATA 8'h01, 55,55,55,55, ctrl 8'hF5 -> ch_load_tick_o pulse with ch_data_o=32'h5555_5555, ch_sel_o=15, ch_mode_o=1.
- DATA with ctrl 8'h32 (tag=2'b10) -> err_tick_o, no ch_load_tick_o.
- Unknown byte 8'h7E in IDLE -> err_tick_o, stays IDLE; subsequent valid FREQ packet is accepted.
- DATA 8'h01, 2 bytes, then silence of TIMEOUT_CYCLES -> err_tick_o, IDLE; next full DATA packet loads correctly.
- Assert rst_ni=0 for one cycle after 3 FREQ bytes -> all outputs at reset values, no ticks.
